// File: rtl/alu_mul_seq_if.sv
// Request/response and Alu operand bundle for the shift-add multiplier.
// Single-cycle start handshake; start is ignored while the multiplier is busy.
interface alu_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             zero_flag;
    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    logic [2:0]       alu_f;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    // Environment side: issues requests and hosts the Alu instance.
    modport master (
        output start, a, b, alu_result, alu_zero,
        input  busy, done, product, zero_flag, alu_op1, alu_op2, alu_f
    );

    // Multiplier side: accepts requests and drives the Alu operands.
    modport slave (
        input  start, a, b, alu_result, alu_zero,
        output busy, done, product, zero_flag, alu_op1, alu_op2, alu_f
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier using an external Alu adder; max(1, msb(b)+1) RUN cycles, done one cycle later.
// No backpressure: start is taken in IDLE or DONE only and ignored while busy.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             zero_flag;
    logic             last_step;

    // Stop early once no multiplier bits remain above the one being consumed.
    assign last_step = (mplier[WIDTH-1:1] == '0) || (count == CW'(WIDTH - 1));

    assign bus.alu_op1   = acc;
    assign bus.alu_op2   = (state == RUN && mplier[0]) ? mcand : '0;
    assign bus.alu_f     = 3'b010;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.product   = product;
    assign bus.zero_flag = zero_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        acc    <= '0;
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= bus.alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last_step) begin
                        product   <= bus.alu_result;
                        zero_flag <= bus.alu_zero;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural Alu adder on the interface.
module tb_alu_mul_seq;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] p;
        logic         z;
        int           runs;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_mul_seq_if #(.WIDTH(W)) bus ();

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Alu model: add only, zero flag on the sum.
    assign bus.alu_result = bus.alu_op1 + bus.alu_op2;
    assign bus.alu_zero   = (bus.alu_result == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops on every done pulse, also counts busy cycles per operation.
    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("alu_f", {29'd0, bus.alu_f}, 32'd2);
                if (!bus.busy) chk("alu_op2_idle", bus.alu_op2, 32'd0);
                if (bus.done) begin
                    chk("busy_when_done", {31'd0, bus.busy}, 32'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pending operation");
                    end else begin
                        e = sb.pop_front();
                        chk("product", bus.product, e.p);
                        chk("zero_flag", {31'd0, bus.zero_flag}, {31'd0, e.z});
                        chk("run_cycles", busy_cnt, e.runs);
                    end
                    busy_cnt = 0;
                end else if (bus.busy) begin
                    busy_cnt++;
                end else begin
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] p, input logic z, input int runs);
        exp_t e;
        e.p = p; e.z = z; e.runs = runs;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input logic z, input int runs);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        push(p, z, runs);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : stim
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_product", bus.product, 32'd0);
        chk("rst_zero", {31'd0, bus.zero_flag}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(32'd3, 32'd5, 32'd15, 1'b0, 3);
        drain("mul_3x5");
        issue(32'h12345678, 32'd0, 32'd0, 1'b1, 1);
        drain("mul_bzero");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32);
        drain("mul_ones");
        issue(32'h00010000, 32'h00010000, 32'd0, 1'b1, 17);
        drain("mul_overflow");
        issue(32'd6, 32'd7, 32'd42, 1'b0, 3);
        drain("mul_6x7");

        // Second start while running must be ignored.
        bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        push(32'd15, 1'b0, 3);
        @(negedge clk);
        bus.a = 32'd7; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        drain("start_in_run");

        // Reset one cycle mid-operation discards it.
        issue(32'd3, 32'd5, 32'd15, 1'b0, 3);
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_product", bus.product, 32'd0);
        repeat (40) @(negedge clk);

        // Start held high: three back-to-back operations, done every third cycle.
        bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        push(32'd6, 1'b0, 2);
        push(32'd6, 1'b0, 2);
        push(32'd6, 1'b0, 2);
        repeat (9) @(negedge clk);
        bus.start = 1'b0;
        drain("held_start");
        chk("final_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("final_product", bus.product, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
